// File: rtl/tag_free_list_pkg.sv
// tag_free_list_pkg: shared defaults and types for the reservation-tag free list
package tag_free_list_pkg;

    localparam int DEF_TAG_WIDTH = 6;
    localparam int DEF_NUM_TAGS  = 64;
    localparam int DEF_NUM_RET   = 2;
    localparam int MAX_RET       = 4;

    typedef logic [DEF_TAG_WIDTH-1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } cdb_ret_t;

endpackage

// File: rtl/tag_free_list_ptr.sv
// free_list_ptr: circular pointer advanced by 0..MAX_INC steps, wrapping at N-1 -> 0
module free_list_ptr
    import tag_free_list_pkg::*;
#(
    parameter int N       = DEF_NUM_TAGS,
    parameter int MAX_INC = MAX_RET,
    parameter int PW      = $clog2(N),
    parameter int IW      = $clog2(MAX_INC + 1)
) (
    input  logic [PW-1:0] ptr,
    input  logic [IW-1:0] inc,
    output logic [PW-1:0] next
);

    // Step one slot at a time with an explicit wrap compare so depths that
    // are not a power of two still wrap correctly.
    always_comb begin
        next = ptr;
        for (int i = 0; i < MAX_INC; i++)
            if (i < int'(inc))
                next = (next == PW'(N - 1)) ? '0 : next + 1'b1;
    end

endmodule

// File: rtl/tag_free_list.sv
// tag_free_list: circular free-list of reservation tags, one alloc and up to
// NUM_RET CDB returns per cycle. Optional same-cycle return-to-alloc bypass
// on an empty list is enabled by defining TAG_FREE_LIST_BYPASS_EN.
module tag_free_list
    import tag_free_list_pkg::*;
#(
    parameter int TAG_WIDTH = DEF_TAG_WIDTH,
    parameter int NUM_TAGS  = DEF_NUM_TAGS,
    parameter int NUM_RET   = DEF_NUM_RET,
    parameter int CNT_W     = $clog2(NUM_TAGS + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         alloc_req,
    output logic [TAG_WIDTH-1:0]         alloc_tag,
    output logic                         alloc_valid,
    input  logic [NUM_RET-1:0]           ret_valid,
    input  logic [NUM_RET*TAG_WIDTH-1:0] ret_tag,
    output logic [CNT_W-1:0]             count,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);

    localparam int PTR_W = $clog2(NUM_TAGS);
    localparam int INC_W = $clog2(NUM_RET + 1);

    logic [TAG_WIDTH-1:0] mem [NUM_TAGS];
    logic [TAG_WIDTH-1:0] tag_in [NUM_RET];
    logic [PTR_W-1:0]     rd_ptr, wr_ptr, rd_next;
    logic [PTR_W-1:0]     wr_addr [NUM_RET+1];
    logic [INC_W-1:0]     ofs [NUM_RET+1];
    logic [NUM_RET-1:0]   wr_en;
    logic [CNT_W-1:0]     count_next;
    logic                 pop, bypass, bad;
    int                   occ, acc;

    for (genvar i = 0; i < NUM_RET; i++) begin : g_tag
        assign tag_in[i] = ret_tag[i*TAG_WIDTH +: TAG_WIDTH];
    end

`ifdef TAG_FREE_LIST_BYPASS_EN
    assign bypass = empty && ret_valid[0] && (32'(tag_in[0]) < NUM_TAGS);
`else
    assign bypass = 1'b0;
`endif

    // Head of list is shown ahead; the bypass forwards port 0 onto an empty list.
    always_comb begin
        empty       = count == '0;
        full        = count == CNT_W'(NUM_TAGS);
        alloc_valid = !empty || bypass;
        alloc_tag   = bypass ? tag_in[0] : mem[rd_ptr];
        pop         = alloc_req && !empty;
    end

    // Accept returns in port order against the capacity left after this
    // cycle's pop; each accepted port takes the next slot after the tail.
    always_comb begin
        occ   = int'(count) - int'(pop);
        acc   = 0;
        bad   = 1'b0;
        wr_en = '0;
        for (int i = 0; i < NUM_RET; i++) begin
            ofs[i] = INC_W'(acc);
            if (ret_valid[i] && !(i == 0 && bypass && alloc_req)) begin
                if (32'(tag_in[i]) >= NUM_TAGS || occ + acc >= NUM_TAGS) begin
                    bad = 1'b1;
                end else begin
                    wr_en[i] = 1'b1;
                    acc      = acc + 1;
                end
            end
        end
        ofs[NUM_RET] = INC_W'(acc);
        count_next   = CNT_W'(occ + acc);
    end

    free_list_ptr #(.N(NUM_TAGS), .MAX_INC(NUM_RET)) u_rd (
        .ptr  (rd_ptr),
        .inc  (INC_W'(pop)),
        .next (rd_next)
    );

    // Slot for each return port; the last instance is the new tail pointer.
    for (genvar w = 0; w <= NUM_RET; w++) begin : g_wr
        free_list_ptr #(.N(NUM_TAGS), .MAX_INC(NUM_RET)) u_wr (
            .ptr  (wr_ptr),
            .inc  (ofs[w]),
            .next (wr_addr[w])
        );
    end

    // Reset and flush both refill the list with every tag in ascending order.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int k = 0; k < NUM_TAGS; k++)
                mem[k] <= TAG_WIDTH'(k);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= CNT_W'(NUM_TAGS);
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_addr[NUM_RET];
            count  <= count_next;
            for (int i = 0; i < NUM_RET; i++)
                if (wr_en[i])
                    mem[wr_addr[i]] <= tag_in[i];
        end
    end

    // Sticky error survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset)
            err <= 1'b0;
        else if (!flush && bad)
            err <= 1'b1;
    end

endmodule

// File: tb/tb_tag_free_list.sv
// tb_tag_free_list: table/scoreboard bench for a 64-tag and a 48-tag free list
module tb_tag_free_list;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, alloc_req;
    logic [1:0]  ret_valid;
    logic [11:0] ret_tag;
    logic [5:0]  alloc_tag;
    logic        alloc_valid, empty, full, err;
    logic [6:0]  count;

    logic        b_flush, b_req;
    logic [1:0]  b_rv;
    logic [11:0] b_rt;
    logic [5:0]  b_tag;
    logic        b_valid, b_empty, b_full, b_err;
    logic [5:0]  b_count;

    tag_free_list #(.TAG_WIDTH(6), .NUM_TAGS(64), .NUM_RET(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .alloc_req(alloc_req),
        .alloc_tag(alloc_tag), .alloc_valid(alloc_valid), .ret_valid(ret_valid),
        .ret_tag(ret_tag), .count(count), .empty(empty), .full(full), .err(err)
    );

    tag_free_list #(.TAG_WIDTH(6), .NUM_TAGS(48), .NUM_RET(2)) dut48 (
        .clk(clk), .reset(reset), .flush(b_flush), .alloc_req(b_req),
        .alloc_tag(b_tag), .alloc_valid(b_valid), .ret_valid(b_rv),
        .ret_tag(b_rt), .count(b_count), .empty(b_empty), .full(b_full), .err(b_err)
    );

    typedef struct {
        bit         b;
        bit         f;
        bit         a;
        logic [1:0] rv;
        int         t1;
        int         t0;
        int         cnt;
        int         tag;
        bit         vld;
        bit         er;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   nvec = 0;
    int   nbad = 0;

    function automatic vec_t mk(bit b, bit f, bit a, logic [1:0] rv, int t1, int t0,
                                int cnt, int tag, bit vld, bit er);
        vec_t v;
        v.b = b; v.f = f; v.a = a; v.rv = rv; v.t1 = t1; v.t0 = t0;
        v.cnt = cnt; v.tag = tag; v.vld = vld; v.er = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check(input vec_t e);
        if (e.b) begin
            chk("count48", 32'(b_count), e.cnt);
            chk("valid48", 32'(b_valid), 32'(e.vld));
            chk("err48", 32'(b_err), 32'(e.er));
            chk("empty48", 32'(b_empty), 32'(e.cnt == 0));
            chk("full48", 32'(b_full), 32'(e.cnt == 48));
            if (e.vld) chk("tag48", 32'(b_tag), e.tag);
        end else begin
            chk("count", 32'(count), e.cnt);
            chk("valid", 32'(alloc_valid), 32'(e.vld));
            chk("err", 32'(err), 32'(e.er));
            chk("empty", 32'(empty), 32'(e.cnt == 0));
            chk("full", 32'(full), 32'(e.cnt == 64));
            if (e.vld) chk("tag", 32'(alloc_tag), e.tag);
        end
    endtask

    task automatic idle();
        flush = 0; alloc_req = 0; ret_valid = 0; ret_tag = 0;
        b_flush = 0; b_req = 0; b_rv = 0; b_rt = 0;
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        if (v.b) begin
            b_flush = v.f; b_req = v.a; b_rv = v.rv; b_rt = {6'(v.t1), 6'(v.t0)};
        end else begin
            flush = v.f; alloc_req = v.a; ret_valid = v.rv; ret_tag = {6'(v.t1), 6'(v.t0)};
        end
        sbq.push_back(v);
    endtask

    task automatic finish_cyc();
        vec_t e;
        @(posedge clk);
        #1;
        idle();
        if (sbq.size() == 0) begin
            nbad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sbq.pop_front();
            check(e);
        end
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        finish_cyc();
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    initial begin
        reset = 1;
        idle();
        // Phase 3 table: paired returns, pop+return, full overflow, flush keeps err.
        tbl.push_back(mk(0, 0, 0, 2'b11, 9, 5, 2, 5, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'b00, 0, 0, 1, 9, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0));
        for (int j = 0; j < 5; j++)
            tbl.push_back(mk(0, 0, 0, 2'b11, 31 + 2*j, 30 + 2*j, 2*j + 2, 30, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2'b01, 0, 20, 10, 31, 1, 0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 0, 1, 2'b00, 0, 0, 9 - k, (k < 8) ? 32 + k : 20, k < 9, 0));
        tbl.push_back(mk(0, 1, 0, 2'b00, 0, 0, 64, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 2'b01, 0, 3, 64, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 2'b11, 8, 9, 64, 0, 1, 1));

        // Phase 1: reset state and 64 in-order allocations.
        do_reset();
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 64, 0, 1, 0));
        check(mk(1, 0, 0, 0, 0, 0, 48, 0, 1, 0));
        for (int i = 0; i < 64; i++)
            apply(mk(0, 0, 1, 2'b00, 0, 0, 63 - i, i + 1, i < 63, 0));

        // Phase 2: return and alloc in the same cycle on an empty list.
        drive(mk(0, 0, 1, 2'b01, 0, 7,
`ifdef TAG_FREE_LIST_BYPASS_EN
                 0, 0, 0, 0));
`else
                 1, 7, 1, 0));
`endif
        #1;
`ifdef TAG_FREE_LIST_BYPASS_EN
        chk("bypass_valid", 32'(alloc_valid), 1);
        chk("bypass_tag", 32'(alloc_tag), 7);
        finish_cyc();
        apply(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
`else
        chk("nobypass_valid", 32'(alloc_valid), 0);
        finish_cyc();
        apply(mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Phase 4: capacity counted after pop, port priority, flush after 30 allocs.
        do_reset();
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 64, 0, 1, 0));
        apply(mk(0, 0, 1, 2'b01, 0, 0, 64, 1, 1, 0));
        apply(mk(0, 0, 1, 2'b11, 40, 0, 64, 2, 1, 1));
        for (int i = 0; i < 28; i++)
            apply(mk(0, 0, 1, 2'b00, 0, 0, 63 - i, 3 + i, 1, 1));
        apply(mk(0, 1, 1, 2'b11, 1, 2, 64, 0, 1, 1));
        do_reset();
        #1;
        check(mk(0, 0, 0, 0, 0, 0, 64, 0, 1, 0));

        // Phase 5: 48-deep list, pointer wrap and out-of-range return.
        for (int i = 0; i < 48; i++)
            apply(mk(1, 0, 1, 2'b00, 0, 0, 47 - i, i + 1, i < 47, 0));
        for (int j = 0; j < 24; j++)
            apply(mk(1, 0, 0, 2'b11, 46 - 2*j, 47 - 2*j, 2*j + 2, 47, 1, 0));
        apply(mk(1, 0, 1, 2'b00, 0, 0, 47, 46, 1, 0));
        apply(mk(1, 0, 0, 2'b01, 0, 50, 47, 46, 1, 1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
